lbp_hist: RTL and testbench

Downstream consumer of the LBP stage. Captures the stream of 8-bit LBP codes written per interior pixel and accumulates a 256-bin histogram. When the LBP stage raises `finish`, it streams all 256 bins out over a valid/ready port for the feature/matching stage. Sits between the LBP engine and the descriptor consumer, sharing its 128x128 image geometry.

---
 rtl/lbp_pkg.sv | 23 ++
 rtl/lbp_hist_if.sv | 16 +
 rtl/lbp_hist_ram.sv | 19 +
 rtl/lbp_hist.sv | 103 ++++++++++
 tb/tb_lbp_hist.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lbp_pkg.sv
// lbp_pkg: shared geometry, state encoding and address helpers for the LBP histogram
package lbp_pkg;
   localparam int IMG_W    = 128;
   localparam int CNT_W    = 14;
   localparam int NUM_BINS = 256;
   localparam int PIX_W    = $clog2(IMG_W);
   localparam int ADDR_W   = 2 * PIX_W;
   localparam logic [PIX_W-1:0] EDGE_HI = PIX_W'(IMG_W - 1);

   typedef enum logic [1:0] {ACCUM, DRAIN, DUMP, DONE} state_t;

   function automatic logic [PIX_W-1:0] row_of(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:PIX_W];
   endfunction

   function automatic logic [PIX_W-1:0] col_of(input logic [ADDR_W-1:0] a);
      return a[PIX_W-1:0];
   endfunction

   function automatic logic is_border(input logic [ADDR_W-1:0] a);
      return row_of(a) == '0 || row_of(a) == EDGE_HI || col_of(a) == '0 || col_of(a) == EDGE_HI;
   endfunction
endpackage

// File: rtl/lbp_hist_if.sv
// lbp_hist_if: LBP code stream in and histogram bin stream out
interface lbp_hist_if;
   import lbp_pkg::*;
   logic              lbp_valid;
   logic [ADDR_W-1:0] lbp_addr;
   logic [7:0]        lbp_data;
   logic              finish;
   logic              hist_valid;
   logic              hist_ready;
   logic [7:0]        hist_bin;
   logic [CNT_W-1:0]  hist_count;
   modport master (output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
                   input  hist_valid, hist_bin, hist_count);
   modport slave  (input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
                   output hist_valid, hist_bin, hist_count);
endinterface

// File: rtl/lbp_hist_ram.sv
// lbp_hist_ram: 256 x CNT_W bin store, sync read returning old data on collision
module lbp_hist_ram
   import lbp_pkg::*;
(
   input  logic             clk,
   input  logic [7:0]       raddr,
   output logic [CNT_W-1:0] rdata,
   input  logic             we,
   input  logic [7:0]       waddr,
   input  logic [CNT_W-1:0] wdata
);
   logic [CNT_W-1:0] mem [NUM_BINS];

   // one write port and one registered read port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: accumulate a 256-bin LBP histogram, then stream every bin out
module lbp_hist
   import lbp_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   lbp_hist_if.slave        bus,
   output logic             hist_done,
   output logic [CNT_W-1:0] pix_count,
   output logic             addr_err
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state, state_nxt;
   logic [NUM_BINS-1:0] touched;
   logic                accept, good, s1_v, fwd_v, pf_v, load, hv;
   logic [7:0]          s1_bin, fwd_bin, raddr, fetch_bin, hb;
   logic [CNT_W-1:0]    rdata, old_cnt, new_cnt, fwd_val, hc;

   assign accept = bus.lbp_valid && state == ACCUM;
   assign good   = accept && !is_border(bus.lbp_addr);
   assign load   = state == DUMP && pf_v && (!hv || bus.hist_ready);

   assign bus.hist_valid = hv;
   assign bus.hist_bin   = hb;
   assign bus.hist_count = hc;

   // untouched bins read as zero; a write from the previous cycle overrides the stale RAM read
   always_comb begin
      old_cnt = (fwd_v && fwd_bin == s1_bin) ? fwd_val : touched[s1_bin] ? rdata : '0;
      new_cnt = old_cnt == CNT_MAX ? old_cnt : old_cnt + CNT_W'(1);
      raddr   = state == DUMP ? (load ? fetch_bin + 8'd1 : fetch_bin) : state == DRAIN ? 8'd0 : bus.lbp_data;
   end

   lbp_hist_ram u_ram (
      .clk   (clk),
      .raddr (raddr),
      .rdata (rdata),
      .we    (s1_v),
      .waddr (s1_bin),
      .wdata (new_cnt)
   );

   // state register
   always_ff @(posedge clk) state <= reset ? ACCUM : state_nxt;

   // next state: drain waits for the last write so the bin-0 prefetch sees it
   always_comb begin
      state_nxt = state;
      if (state == ACCUM && bus.finish) state_nxt = DRAIN;
      if (state == DRAIN && !s1_v) state_nxt = DUMP;
      if (state == DUMP && hv && bus.hist_ready && hb == 8'hFF) state_nxt = DONE;
   end

   // read-modify-write update pipeline, touched flags and input statistics
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v      <= 1'b0;
         s1_bin    <= '0;
         fwd_v     <= 1'b0;
         fwd_bin   <= '0;
         fwd_val   <= '0;
         touched   <= '0;
         pix_count <= '0;
         addr_err  <= 1'b0;
      end else begin
         s1_v    <= good;
         s1_bin  <= bus.lbp_data;
         fwd_v   <= s1_v;
         fwd_bin <= s1_bin;
         fwd_val <= new_cnt;
         if (s1_v) touched[s1_bin] <= 1'b1;
         if (good && pix_count != CNT_MAX) pix_count <= pix_count + CNT_W'(1);
         if (accept && is_border(bus.lbp_addr)) addr_err <= 1'b1;
      end
   end

   // dump: rdata always holds fetch_bin, loaded into the output slot when it is free
   always_ff @(posedge clk) begin
      if (reset) begin
         pf_v      <= 1'b0;
         fetch_bin <= '0;
         hv        <= 1'b0;
         hb        <= '0;
         hc        <= '0;
         hist_done <= 1'b0;
      end else begin
         if (state == DRAIN && !s1_v) begin
            pf_v      <= 1'b1;
            fetch_bin <= '0;
         end else if (load) begin
            pf_v      <= fetch_bin != 8'hFF;
            fetch_bin <= fetch_bin + 8'd1;
         end
         if (load) begin
            hv <= 1'b1;
            hb <= fetch_bin;
            hc <= touched[fetch_bin] ? rdata : '0;
         end else if (hv && bus.hist_ready) hv <= 1'b0;
         if (hv && bus.hist_ready && hb == 8'hFF) hist_done <= 1'b1;
      end
   end
endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: table-driven frames plus hand sequences for full frame, saturation and reset abort
module tb_lbp_hist;
   import lbp_pkg::*;

   typedef struct {
      int          frame;
      logic [13:0] addr;
      logic [7:0]  code;
   } vec_t;

   typedef struct {
      bit fin_last;
      bit slow;
      int pix;
      int err;
      int b0, c0, b1, c1;
   } frame_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic hist_done, addr_err;
   logic [CNT_W-1:0] pix_count;
   int n_chk = 0, n_err = 0;
   int exp_h [256];
   vec_t vecs [17];
   frame_t fr [5];

   always #5 clk = ~clk;

   lbp_hist_if bus ();

   lbp_hist dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .hist_done (hist_done),
      .pix_count (pix_count),
      .addr_err  (addr_err)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b1;
      bus.lbp_valid = 1'b0;
      bus.finish = 1'b0;
      bus.hist_ready = 1'b0;
      @(negedge clk);
      chk("rst_hist_valid", bus.hist_valid, 0);
      chk("rst_hist_bin", bus.hist_bin, 0);
      chk("rst_hist_count", bus.hist_count, 0);
      chk("rst_hist_done", hist_done, 0);
      chk("rst_pix_count", pix_count, 0);
      chk("rst_addr_err", addr_err, 0);
      reset = 1'b0;
      foreach (exp_h[i]) exp_h[i] = 0;
   endtask

   task automatic send(input logic [13:0] a, input logic [7:0] d, input bit fin);
      @(negedge clk);
      bus.lbp_valid = 1'b1;
      bus.lbp_addr = a;
      bus.lbp_data = d;
      bus.finish = fin;
   endtask

   task automatic raise_finish;
      @(negedge clk);
      bus.lbp_valid = 1'b0;
      bus.finish = 1'b1;
   endtask

   task automatic dump(input bit slow, input int stop);
      int w, idx, cyc, pb, pc;
      bit stalled, rdy;
      w = 0; idx = 0; cyc = 0; pb = 0; pc = 0; stalled = 0;
      bus.hist_ready = 1'b0;
      do begin
         @(negedge clk);
         w++;
         bus.lbp_valid = 1'b0;
      end while (!bus.hist_valid && w < 8);
      chk("first_valid_within_4", int'(bus.hist_valid && w <= 4), 1);
      while (bus.hist_valid !== 1'bx && idx < stop && cyc < 3000 && n_err < 40) begin
         if (cyc > 0) @(negedge clk);
         cyc++;
         chk("dump_valid", bus.hist_valid, 1);
         chk("done_early", hist_done, 0);
         if (stalled) begin
            chk("stall_bin", bus.hist_bin, pb);
            chk("stall_count", bus.hist_count, pc);
         end
         rdy = !slow || (cyc % 3 == 0);
         bus.hist_ready = rdy;
         if (bus.hist_valid && rdy) begin
            chk("dump_bin_order", bus.hist_bin, idx);
            chk($sformatf("bin_%0d_count", idx), bus.hist_count, exp_h[idx]);
            idx++;
         end
         stalled = bus.hist_valid && !rdy;
         pb = bus.hist_bin;
         pc = bus.hist_count;
      end
      chk("dump_bins_handshaken", idx, stop);
      if (stop == 256) begin
         @(negedge clk);
         bus.hist_ready = 1'b0;
         chk("hist_done_after_255", hist_done, 1);
         chk("valid_low_after_done", bus.hist_valid, 0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int last;
      bus.lbp_valid = 1'b0;
      bus.lbp_addr = '0;
      bus.lbp_data = '0;
      bus.finish = 1'b0;
      bus.hist_ready = 1'b0;

      vecs = '{
         '{0, 14'd129,   8'h5A},
         '{1, 14'd129,   8'h33}, '{1, 14'd130,  8'h33}, '{1, 14'd131,   8'h33}, '{1, 14'd132,  8'h34},
         '{2, 14'd0,     8'h10}, '{2, 14'd127,  8'h11}, '{2, 14'd16256, 8'h12}, '{2, 14'd200,  8'h13},
         '{3, 14'd129,   8'h40}, '{3, 14'd130,  8'h41}, '{3, 14'd131,   8'h40}, '{3, 14'd132,  8'h40},
         '{4, 14'd128,   8'h20}, '{4, 14'd255,  8'h21}, '{4, 14'd16383, 8'h22}, '{4, 14'd1000, 8'h77}
      };
      fr = '{
         '{0, 0, 1, 0, 'h5A, 1, 0,    0},
         '{0, 1, 4, 0, 'h33, 3, 'h34, 1},
         '{1, 0, 1, 1, 'h13, 1, 0,    0},
         '{1, 1, 4, 0, 'h40, 3, 'h41, 1},
         '{0, 0, 1, 1, 'h77, 1, 0,    0}
      };

      for (int f = 0; f < 5; f++) begin
         do_reset;
         exp_h[fr[f].b0] += fr[f].c0;
         exp_h[fr[f].b1] += fr[f].c1;
         last = -1;
         for (int v = 0; v < 17; v++) if (vecs[v].frame == f) last = v;
         for (int v = 0; v < 17; v++)
            if (vecs[v].frame == f) send(vecs[v].addr, vecs[v].code, fr[f].fin_last && v == last);
         if (!fr[f].fin_last) raise_finish;
         dump(fr[f].slow, 256);
         chk($sformatf("frame%0d_pix_count", f), pix_count, fr[f].pix);
         chk($sformatf("frame%0d_addr_err", f), addr_err, fr[f].err);
         send(14'd129, 8'h5A, 1'b1);
         @(negedge clk);
         bus.lbp_valid = 1'b0;
         @(negedge clk);
         chk("pix_ignored_in_done", pix_count, fr[f].pix);
         chk("done_sticky", hist_done, 1);
      end

      do_reset;
      for (int r = 1; r <= 126; r++)
         for (int c = 1; c <= 126; c++)
            send({7'(r), 7'(c)}, 8'hFF, r == 126 && c == 126);
      exp_h[255] = 15876;
      dump(1'b0, 256);
      chk("full_frame_pix_count", pix_count, 15876);
      chk("full_frame_addr_err", addr_err, 0);

      do_reset;
      for (int i = 0; i < 16390; i++) send(14'd129, 8'h00, i == 16389);
      exp_h[0] = 16383;
      dump(1'b0, 256);

      do_reset;
      send(14'd129, 8'hC8, 1'b0);
      send(14'd130, 8'hC8, 1'b0);
      send(14'd131, 8'h01, 1'b0);
      send(14'd132, 8'h01, 1'b0);
      send(14'd133, 8'h01, 1'b0);
      send(14'd134, 8'h05, 1'b1);
      exp_h[1] = 3;
      exp_h[5] = 1;
      exp_h[200] = 2;
      dump(1'b1, 100);
      do_reset;
      for (int i = 0; i < 5; i++) send(14'(300 + i), 8'h01, i == 4);
      exp_h[1] = 5;
      dump(1'b0, 256);
      chk("after_abort_pix_count", pix_count, 5);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
